// File: rtl/bht_update_queue.sv
// Branch-history-table update queue: buffers resolved branches until the predictor can take them.
// Optional same-cycle forwarding into an empty queue is enabled by defining BHT_UPDATE_BYPASS_EN.
package config_pkg;
    typedef struct packed {
        int unsigned VLEN;
        int unsigned BHTIndexBits;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd0, BHTIndexBits: 32'd0};
endpackage

module bht_update_queue #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg      = config_pkg::cva6_cfg_empty,
    parameter type                   bht_update_t = logic,
    parameter int unsigned           DEPTH        = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_bp_i,
    input  logic                            debug_mode_i,
    input  logic [$bits(bht_update_t)-1:0]  resolved_update_i,
    input  logic                            stall_i,
    output logic [$bits(bht_update_t)-1:0]  bht_update_o,
    output logic [$clog2(DEPTH+1)-1:0]      count_o,
    output logic [15:0]                     drop_cnt_o
);
    localparam int unsigned   W    = $bits(bht_update_t);
    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Field layout comes from bht_update_t itself; the core config only travels with the instance.
    if (CVA6Cfg.VLEN != 0) begin : g_cfg_present
    end

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_drop_cnt;

    logic          w_in_ok;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_bypass;
    logic [W-1:0]  w_head;

    // valid is the first member of the packed update struct, hence its MSB.
    assign w_in_ok = resolved_update_i[W-1] & ~debug_mode_i & ~flush_bp_i;
    assign w_full  = (r_count == FULL);
    assign w_pop   = rst_ni & (r_count != '0) & ~stall_i & ~flush_bp_i;

`ifdef BHT_UPDATE_BYPASS_EN
    assign w_bypass = rst_ni & (r_count == '0) & ~stall_i & w_in_ok;
`else
    assign w_bypass = 1'b0;
`endif

    // A pop in the same cycle frees the slot the push needs, so a full queue still accepts.
    assign w_push = w_in_ok & (~w_full | w_pop) & ~w_bypass;
    assign w_drop = w_in_ok & w_full & ~w_pop;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        w_head       = r_mem[r_rd_ptr];
        w_head[W-1]  = 1'b1;
        bht_update_o = '0;
        if (w_bypass) begin
            bht_update_o = resolved_update_i;
        end else if (w_pop) begin
            bht_update_o = w_head;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else if (flush_bp_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; no entry is visible until count_o covers it.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= resolved_update_i;
        end
    end

    assign count_o    = r_count;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: doc/bht_update_queue.md
BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, meaning core configuration (VLEN, predictor index widths).
REQ-002 SHALL have parameter bht_update_t, default logic, meaning the predictor update struct: valid, pc, taken, metadata.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two from 2 to 16.
REQ-004 SHALL have port clk_i  input  1  core clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port flush_bp_i  input  1  clears all queued updates.
REQ-007 SHALL have port debug_mode_i  input  1  when high, incoming updates are discarded.
REQ-008 SHALL have port resolved_update_i  input  $bits(bht_update_t)  resolved branch from execute; the .valid field qualifies it.
REQ-009 SHALL have port stall_i  input  1  when high, the downstream predictor cannot accept an update this cycle.
REQ-010 SHALL have port bht_update_o  output  $bits(bht_update_t)  update presented to the predictor's bht_update_i port.
REQ-011 SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy.
REQ-012 SHALL have port drop_cnt_o  output  16  saturating count of updates dropped because the queue was full.

Function
REQ-013 SHALL hold updates in a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-014 SHALL push resolved_update_i when .valid=1, debug_mode_i=0, flush_bp_i=0 and the queue is not full (after accounting for a pop in the same cycle).
REQ-015 SHALL drive bht_update_o with the head entry and .valid=1 when count_o>0 and stall_i=0; otherwise all fields SHALL be 0.
REQ-016 SHALL pop the head in every cycle in which bht_update_o.valid=1.
REQ-017 SHALL expose a pushed entry no earlier than the following cycle: write in cycle N, earliest output in cycle N+1.
REQ-018 SHALL, when full and a pop occurs in the same cycle, accept the push; count_o remains DEPTH.
REQ-019 SHALL, when full with no pop, drop the incoming update, leave the queue unchanged, and increment drop_cnt_o, saturating at 16'hFFFF.
REQ-020 SHALL update count_o as +1 for a push only, -1 for a pop only, and unchanged for both or neither.
REQ-021 SHALL, on flush_bp_i=1, zero both pointers and count_o in the next cycle, suppress output in the flush cycle, and ignore same-cycle input; drop_cnt_o is retained.
REQ-022 SHALL preserve FIFO order; no entry is duplicated, reordered or lost except by flush, debug discard or a full-drop.
REQ-023 SHALL not modify any field of an entry between push and pop.

Reset
REQ-024 SHALL, when rst_ni=0 at a rising edge, clear the pointers, count_o and drop_cnt_o to 0 and drive bht_update_o to all-zero; this holds even if a push or pop is in progress.
REQ-025 SHALL not require the storage array to be reset; its contents are unobservable while count_o=0.

Configuration
REQ-026 SHALL, when BHT_UPDATE_BYPASS_EN is defined and count_o=0, stall_i=0 and a push-eligible input is present, forward resolved_update_i combinationally to bht_update_o in the same cycle without storing it; count_o stays 0.
REQ-027 SHALL, when BHT_UPDATE_BYPASS_EN is undefined, have no combinational path from resolved_update_i to bht_update_o; latency is always at least 1 cycle.

Verification
REQ-028 SHALL cover: DEPTH=4, push pc=0x100, 0x104, 0x108 on consecutive cycles with stall_i=0 -> outputs in the same order, each one cycle after its push; count_o peaks at 1.
REQ-029 SHALL cover: stall_i=1 while pushing 6 updates into DEPTH=4 -> count_o=4, drop_cnt_o=2; after release, the first 4 pcs drain in order.
REQ-030 SHALL cover: full queue, stall_i=0, push in the same cycle -> push accepted, count_o=4, drop_cnt_o unchanged.
REQ-031 SHALL cover: 3 entries queued, flush_bp_i=1 with a valid input -> next cycle count_o=0, bht_update_o.valid=0, input not stored.
REQ-032 SHALL cover: debug_mode_i=1 with 5 valid inputs -> count_o stays 0, drop_cnt_o unchanged, no output.
REQ-033 SHALL cover: with BHT_UPDATE_BYPASS_EN defined, empty queue, pc=0x200 input -> bht_update_o.pc=0x200 with valid=1 in the same cycle, count_o=0.
